// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-port synchronous RAM between the
// instruction-fetch port (read-only) and the data port (lw/sw). Data
// accesses with addr[31]=1 go to memory-mapped I/O: loads read the
// 12-bit switches, stores write the 12-bit LED register.
//
// Ports:
//   clk, rst                        clock, synchronous active-high reset
//   i_ce, i_addr                    fetch request (held until i_ready)
//   i_rdata, i_ready                fetch data and one-cycle completion pulse
//   d_ce, d_we, d_addr, d_wdata     data request (held until d_ready)
//   d_rdata, d_ready                load data and one-cycle completion pulse
//   ram_ce, ram_we, ram_addr,
//   ram_wdata, ram_rdata            RAM side (read data one cycle after ram_ce)
//   switch_on, led_out              memory-mapped I/O
//   stall_req                       pipeline stall while a request is pending
module mem_port_arbiter #(
   parameter int unsigned AW           = 32,
   parameter int unsigned DW           = 32,
   parameter int unsigned STARVE_LIMIT = 4
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          i_ce,
   input  logic [AW-1:0] i_addr,
   output logic [DW-1:0] i_rdata,
   output logic          i_ready,
   input  logic          d_ce,
   input  logic          d_we,
   input  logic [AW-1:0] d_addr,
   input  logic [DW-1:0] d_wdata,
   output logic [DW-1:0] d_rdata,
   output logic          d_ready,
   output logic          ram_ce,
   output logic          ram_we,
   output logic [AW-1:0] ram_addr,
   output logic [DW-1:0] ram_wdata,
   input  logic [DW-1:0] ram_rdata,
   input  logic [11:0]   switch_on,
   output logic [11:0]   led_out,
   output logic          stall_req
);

   localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

   typedef enum logic [1:0] {IDLE, D_ACC, I_ACC, RESP} state_t;

   state_t          state;
   state_t          state_nxt;
   logic            grant_d;
   logic            grant_i;
   logic            owner;      // 1 = data port owns the current access
   logic [AW-1:0]   lat_addr;
   logic            lat_we;
   logic [DW-1:0]   lat_wdata;
   logic            lat_io;
   logic [11:0]     io_rdata;
   logic [3:0]      starve_cnt;

   // State register
   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   // Next state and arbitration: data wins unless the fetch has waited
   // through LIMIT consecutive data grants.
   always_comb begin
      state_nxt = state;
      grant_d   = 1'b0;
      grant_i   = 1'b0;
      case (state)
         IDLE: begin
            if (d_ce && !(i_ce && (starve_cnt == LIMIT))) begin
               grant_d   = 1'b1;
               state_nxt = D_ACC;
            end else if (i_ce) begin
               grant_i   = 1'b1;
               state_nxt = I_ACC;
            end
         end
         D_ACC:   state_nxt = RESP;
         I_ACC:   state_nxt = RESP;
         RESP:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Output decode: everything is a function of state and latched request.
   always_comb begin
      ram_ce    = 1'b0;
      ram_we    = 1'b0;
      ram_addr  = '0;
      ram_wdata = '0;
      i_ready   = 1'b0;
      d_ready   = 1'b0;
      i_rdata   = '0;
      d_rdata   = '0;
      case (state)
         D_ACC: begin
            if (!lat_io) begin
               ram_ce    = 1'b1;
               ram_we    = lat_we;
               ram_addr  = lat_addr;
               ram_wdata = lat_wdata;
            end
         end
         I_ACC: begin
            ram_ce   = 1'b1;
            ram_addr = lat_addr;
         end
         RESP: begin
            if (owner) begin
               d_ready = 1'b1;
               d_rdata = lat_io ? DW'(io_rdata) : ram_rdata;
            end else begin
               i_ready = 1'b1;
               i_rdata = ram_rdata;
            end
         end
         default: ;
      endcase
   end

   assign stall_req = (i_ce & ~i_ready) | (d_ce & ~d_ready);

   // Latch the winning request so later changes on the ports are ignored.
   always_ff @(posedge clk) begin
      if (grant_d) begin
         owner     <= 1'b1;
         lat_addr  <= d_addr;
         lat_we    <= d_we;
         lat_wdata <= d_wdata;
         lat_io    <= d_addr[AW-1];
      end else if (grant_i) begin
         owner     <= 1'b0;
         lat_addr  <= i_addr;
         lat_we    <= 1'b0;
         lat_wdata <= '0;
         lat_io    <= 1'b0;
      end
   end

   // Starvation counter and I/O registers
   always_ff @(posedge clk) begin
      if (rst) begin
         starve_cnt <= '0;
         led_out    <= '0;
         io_rdata   <= '0;
      end else begin
         if (state == IDLE) begin
            if (grant_i || !i_ce)
               starve_cnt <= '0;
            else if (grant_d && (starve_cnt != LIMIT))
               starve_cnt <= starve_cnt + 4'd1;
         end
         // I/O side effect happens on the edge leaving D_ACC
         if ((state == D_ACC) && lat_io) begin
            if (lat_we) led_out  <= lat_wdata[11:0];
            else        io_rdata <= switch_on;
         end
      end
   end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed vector table, hand sequences for arbitration,
// starvation, early ce drop and mid-access reset, then a randomized run
// checked against a transaction-level reference model.
module tb_mem_port_arbiter;

   localparam int unsigned AW    = 32;
   localparam int unsigned DW    = 32;
   localparam int unsigned LIMIT = 4;

   logic          clk = 1'b0;
   logic          rst;
   logic          i_ce;
   logic [AW-1:0] i_addr;
   logic [DW-1:0] i_rdata;
   logic          i_ready;
   logic          d_ce;
   logic          d_we;
   logic [AW-1:0] d_addr;
   logic [DW-1:0] d_wdata;
   logic [DW-1:0] d_rdata;
   logic          d_ready;
   logic          ram_ce;
   logic          ram_we;
   logic [AW-1:0] ram_addr;
   logic [DW-1:0] ram_wdata;
   logic [DW-1:0] ram_rdata;
   logic [11:0]   switch_on;
   logic [11:0]   led_out;
   logic          stall_req;

   always #5 clk = ~clk;

   mem_port_arbiter #(.AW(AW), .DW(DW), .STARVE_LIMIT(LIMIT)) dut (
      .clk(clk), .rst(rst),
      .i_ce(i_ce), .i_addr(i_addr), .i_rdata(i_rdata), .i_ready(i_ready),
      .d_ce(d_ce), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
      .d_rdata(d_rdata), .d_ready(d_ready),
      .ram_ce(ram_ce), .ram_we(ram_we), .ram_addr(ram_addr),
      .ram_wdata(ram_wdata), .ram_rdata(ram_rdata),
      .switch_on(switch_on), .led_out(led_out), .stall_req(stall_req)
   );

   // Synchronous single-port RAM, 256 words indexed by addr[7:0]
   logic [31:0] ram [0:255];
   logic        preload;
   always @(posedge clk) begin
      if (preload) begin
         for (int k = 0; k < 256; k++) ram[k] <= 32'h5A00_0000 | 32'(k);
         ram[16] <= 32'hDEAD_BEEF;
      end else if (ram_ce) begin
         if (ram_we) ram[ram_addr[7:0]] <= ram_wdata;
         else        ram_rdata <= ram[ram_addr[7:0]];
      end
   end

   int checks = 0;
   int errors = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   typedef struct {
      logic        fetch;
      logic        we;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [11:0] sw;
      logic [31:0] exp_rdata;
      logic        exp_ram_ce;
      logic [11:0] exp_led;
   } vec_t;

   vec_t vecs [8];

   // One isolated transaction: request, ACC cycle, RESP cycle, idle cycle.
   task automatic run_vec(input vec_t v, input string tag);
      @(posedge clk); #1;
      switch_on = v.sw;
      if (v.fetch) begin
         i_ce = 1'b1; i_addr = v.addr;
      end else begin
         d_ce = 1'b1; d_we = v.we; d_addr = v.addr; d_wdata = v.wdata;
      end
      @(negedge clk);
      chk({tag, " stall before grant"}, 32'(stall_req), 32'd1);
      @(negedge clk);
      chk({tag, " acc ram_ce"}, 32'(ram_ce), 32'(v.exp_ram_ce));
      chk({tag, " acc ram_we"}, 32'(ram_we), 32'(v.we & v.exp_ram_ce));
      chk({tag, " acc readies"}, {30'd0, i_ready, d_ready}, 32'd0);
      @(negedge clk);
      chk({tag, " resp i_ready"}, 32'(i_ready), 32'(v.fetch));
      chk({tag, " resp d_ready"}, 32'(d_ready), 32'(!v.fetch));
      chk({tag, " resp ram_ce"}, 32'(ram_ce), 32'd0);
      chk({tag, " resp stall"}, 32'(stall_req), 32'd0);
      if (v.fetch)    chk({tag, " i_rdata"}, i_rdata, v.exp_rdata);
      else if (!v.we) chk({tag, " d_rdata"}, d_rdata, v.exp_rdata);
      @(posedge clk); #1;
      i_ce = 1'b0; d_ce = 1'b0;
      @(negedge clk);
      chk({tag, " led_out"}, 32'(led_out), 32'(v.exp_led));
      chk({tag, " idle readies"}, {30'd0, i_ready, d_ready}, 32'd0);
   endtask

   // Reference model state for the randomized phase
   logic [31:0] ref_mem [0:255];
   int          m_timer;      // 0 free, 2 = access cycle, 1 = response cycle
   int          m_cnt;        // data grants taken while a fetch waits
   logic        m_own_d, m_we, m_io;
   logic [31:0] m_addr, m_wdata, m_resp;
   logic [11:0] exp_led;

   initial begin
      #500000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int   d_at, i_at, nd, nd1, nd2, fetches;
      bit   saw_d, saw_i, e_i, e_d, i_done, d_done, gd, gi;
      vec_t v;

      rst = 1'b1; preload = 1'b1;
      i_ce = 0; i_addr = '0; d_ce = 0; d_we = 0; d_addr = '0; d_wdata = '0;
      switch_on = '0;

      vecs[0] = '{1'b0, 1'b0, 32'h0000_0010, 32'h0,          12'h3F0, 32'hDEAD_BEEF, 1'b1, 12'h000};
      vecs[1] = '{1'b0, 1'b1, 32'h8000_0000, 32'h0000_0A5C, 12'h3F0, 32'h0,          1'b0, 12'hA5C};
      vecs[2] = '{1'b0, 1'b0, 32'h8000_0004, 32'h0,          12'h3F0, 32'h0000_03F0, 1'b0, 12'hA5C};
      vecs[3] = '{1'b0, 1'b1, 32'h0000_0040, 32'h1234_5678, 12'h3F0, 32'h0,          1'b1, 12'hA5C};
      vecs[4] = '{1'b1, 1'b0, 32'h0000_0040, 32'h0,          12'h3F0, 32'h1234_5678, 1'b1, 12'hA5C};
      vecs[5] = '{1'b1, 1'b0, 32'h0000_0011, 32'h0,          12'h3F0, 32'h5A00_0011, 1'b1, 12'hA5C};
      vecs[6] = '{1'b0, 1'b1, 32'h8000_0010, 32'hFFFF_F123, 12'h3F0, 32'h0,          1'b0, 12'h123};
      vecs[7] = '{1'b0, 1'b0, 32'h8000_0008, 32'h0,          12'hFFF, 32'h0000_0FFF, 1'b0, 12'h123};

      repeat (3) @(posedge clk);
      #1 rst = 1'b0; preload = 1'b0;
      @(negedge clk);
      chk("reset ram_ce", 32'(ram_ce), 32'd0);
      chk("reset readies", {30'd0, i_ready, d_ready}, 32'd0);
      chk("reset led_out", 32'(led_out), 32'd0);
      chk("reset stall", 32'(stall_req), 32'd0);
      chk("reset rdata", i_rdata | d_rdata, 32'd0);

      for (int n = 0; n < 8; n++) run_vec(vecs[n], $sformatf("vec%0d", n));

      // Simultaneous requests: data first, fetch in the following IDLE
      @(posedge clk); #1;
      i_ce = 1; i_addr = 32'h40; d_ce = 1; d_we = 0; d_addr = 32'h10;
      d_at = -1; i_at = -1;
      for (int s = 0; s < 10; s++) begin
         @(negedge clk);
         saw_d = d_ready; saw_i = i_ready;
         if (saw_d && d_at < 0) begin
            d_at = s; chk("simul d_rdata", d_rdata, 32'hDEAD_BEEF);
         end
         if (saw_i && i_at < 0) begin
            i_at = s; chk("simul i_rdata", i_rdata, 32'h1234_5678);
         end
         @(posedge clk); #1;
         if (saw_d) d_ce = 0;
         if (saw_i) i_ce = 0;
      end
      chk("simul d_ready sample", 32'(d_at), 32'd2);
      chk("simul i_ready sample", 32'(i_at), 32'd5);

      // Starvation: fetch forced through after LIMIT data grants, twice
      @(posedge clk); #1;
      i_ce = 1; i_addr = 32'h40; d_ce = 1; d_we = 0; d_addr = 32'h10;
      nd = 0; nd1 = -1; nd2 = -1; fetches = 0;
      for (int s = 0; s < 80 && fetches < 2; s++) begin
         @(negedge clk);
         saw_d = d_ready; saw_i = i_ready;
         if (saw_d) nd++;
         if (saw_i) begin
            fetches++;
            if (fetches == 1) nd1 = nd;
            else              nd2 = nd - nd1;
         end
         @(posedge clk); #1;
         if (saw_d) d_addr = d_addr + 32'd1;
      end
      i_ce = 0; d_ce = 0;
      chk("starve data grants before fetch 1", 32'(nd1), 32'(LIMIT));
      chk("starve data grants before fetch 2", 32'(nd2), 32'(LIMIT));

      // ce dropped and inputs changed right after grant
      @(posedge clk); #1;
      i_ce = 1; i_addr = 32'h40;
      @(posedge clk); #1;
      i_ce = 0; i_addr = 32'h11;
      @(negedge clk);
      chk("early drop ram_addr", ram_addr, 32'h40);
      @(negedge clk);
      chk("early drop i_ready", 32'(i_ready), 32'd1);
      chk("early drop i_rdata", i_rdata, 32'h1234_5678);
      @(posedge clk); #1;
      d_ce = 1; d_we = 1; d_addr = 32'h30; d_wdata = 32'h0000_0077;
      @(posedge clk); #1;
      d_ce = 0; d_addr = 32'h31; d_wdata = 32'h0;
      @(negedge clk);
      chk("early drop store addr", ram_addr, 32'h30);
      chk("early drop store data", ram_wdata, 32'h77);
      @(negedge clk);
      chk("early drop d_ready", 32'(d_ready), 32'd1);
      v = '{1'b0, 1'b0, 32'h30, 32'h0, 12'h0, 32'h77, 1'b1, 12'h123};
      run_vec(v, "readback 0x30");

      // Reset during D_ACC of a RAM store (the RAM itself sees the write)
      @(posedge clk); #1;
      d_ce = 1; d_we = 1; d_addr = 32'h20; d_wdata = 32'hCAFE_F00D;
      @(posedge clk); #1;
      rst = 1; d_ce = 0;
      @(posedge clk); #1;
      rst = 0;
      saw_d = 0;
      for (int s = 0; s < 3; s++) begin
         @(negedge clk);
         if (d_ready) saw_d = 1;
         if (s == 0) begin
            chk("mid reset led_out", 32'(led_out), 32'd0);
            chk("mid reset ram_ce", 32'(ram_ce), 32'd0);
         end
      end
      chk("mid reset no d_ready", 32'(saw_d), 32'd0);
      v = '{1'b0, 1'b0, 32'h20, 32'h0, 12'h0, 32'hCAFE_F00D, 1'b1, 12'h000};
      run_vec(v, "after reset load");

      // Randomized traffic against a transaction-level model
      for (int k = 0; k < 256; k++) ref_mem[k] = ram[k];
      exp_led = 12'h000;
      m_timer = 0; m_cnt = 0; m_own_d = 0; m_we = 0; m_io = 0;
      m_addr = 0; m_wdata = 0; m_resp = 0;
      i_done = 0; d_done = 0;
      @(posedge clk); #1;
      for (int cyc = 0; cyc < 900; cyc++) begin
         if ((i_done && ($urandom % 2 == 0)) || (!i_done && !i_ce && ($urandom % 3 == 0))) begin
            i_ce = 1; i_addr = 32'($urandom % 256);
         end else if (i_done) i_ce = 0;
         if ((d_done && ($urandom % 2 == 0)) || (!d_done && !d_ce && ($urandom % 3 == 0))) begin
            d_ce = 1; d_we = 1'($urandom); d_wdata = $urandom;
            d_addr = 32'($urandom % 256) | (($urandom % 4 == 0) ? 32'h8000_0000 : 32'h0);
         end else if (d_done) d_ce = 0;
         if ($urandom % 8 == 0) switch_on = 12'($urandom);

         @(negedge clk);
         e_i = (m_timer == 1) && !m_own_d;
         e_d = (m_timer == 1) && m_own_d;
         chk("rnd i_ready", 32'(i_ready), 32'(e_i));
         chk("rnd d_ready", 32'(d_ready), 32'(e_d));
         chk("rnd stall", 32'(stall_req), 32'((i_ce && !e_i) || (d_ce && !e_d)));
         chk("rnd led_out", 32'(led_out), 32'(exp_led));
         if (e_i)              chk("rnd i_rdata", i_rdata, m_resp);
         if (e_d && !m_we)     chk("rnd d_rdata", d_rdata, m_resp);
         if (m_timer != 1)     chk("rnd idle rdata", i_rdata | d_rdata, 32'd0);
         i_done = e_i; d_done = e_d;

         @(posedge clk);
         if (m_timer == 0) begin
            gd = d_ce && !(i_ce && (m_cnt == int'(LIMIT)));
            gi = i_ce && !gd;
            if (gd) begin
               m_own_d = 1; m_we = d_we; m_io = d_addr[31]; m_addr = d_addr; m_wdata = d_wdata;
               m_cnt = i_ce ? ((m_cnt < int'(LIMIT)) ? m_cnt + 1 : m_cnt) : 0;
               m_timer = 2;
            end else if (gi) begin
               m_own_d = 0; m_we = 0; m_io = 0; m_addr = i_addr;
               m_cnt = 0; m_timer = 2;
            end else m_cnt = 0;
         end else begin
            if (m_timer == 2) begin
               if (m_own_d && m_io) begin
                  if (m_we) exp_led = m_wdata[11:0];
                  else      m_resp = {20'd0, switch_on};
               end else if (m_we) ref_mem[m_addr[7:0]] = m_wdata;
               else               m_resp = ref_mem[m_addr[7:0]];
            end
            m_timer = m_timer - 1;
         end
         #1;
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
